// File: rtl/uart_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;
  localparam int   DEFAULT_DIVIDER = 434;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick every DIVIDER clocks, restartable by clear.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIVIDER = DEFAULT_DIVIDER
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(DIVIDER);

  logic [CW-1:0] count;

  assign tick = (count == CW'(DIVIDER - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx line among NUM_REQ byte sources;
// each granted byte is sent as start bit, DATA_W data bits LSB first, stop bit.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  DIVIDER = DEFAULT_DIVIDER,
  parameter int  DATA_W  = 8,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx,
  output logic                      busy,
  output logic [IDW-1:0]            grant_id,
  output logic                      frame_done
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state;
  state_t            state_next;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    winner;
  logic              any_valid;
  logic              accept;
  logic              tick;
  logic [DATA_W-1:0] shift;
  logic [BW-1:0]     bit_idx;
  logic              last_bit;

  // Handshake: a byte transfers in the single cycle where req_valid[i] and
  // req_ready[i] are both high; ready is only offered in IDLE, to the winner.
  always_comb begin
    int idx;
    idx       = 0;
    any_valid = 1'b0;
    winner    = '0;
    // Walk downward so the lowest offset from rr_ptr is the final assignment.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = IDW'(idx);
      end
    end
  end

  assign accept    = (state == IDLE) && any_valid && !reset;
  assign req_ready = accept ? (NUM_REQ'(1) << winner) : '0;
  assign busy      = (state != IDLE);
  assign last_bit  = (bit_idx == BW'(DATA_W - 1));

  uart_baud_tick #(
    .DIVIDER(DIVIDER)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (tick && last_bit) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          frame_done = !reset;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is registered one step ahead of the state so it changes on the
  // same edge that enters each bit period.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx       <= STOP_BIT;
      grant_id <= '0;
      rr_ptr   <= '0;
      shift    <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift    <= req_data[int'(winner)*DATA_W +: DATA_W];
            grant_id <= winner;
            rr_ptr   <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
            tx       <= START_BIT;
            bit_idx  <= '0;
          end else begin
            tx <= STOP_BIT;
          end
        end
        START: begin
          if (tick) begin
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (last_bit) begin
              tx <= STOP_BIT;
            end else begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        STOP: begin
          tx <= STOP_BIT;
        end
        default: tx <= STOP_BIT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: framing, round-robin order, pointer wrap,
// mid-frame reset, data stability and default 434-cycle bit timing.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR  = 4;
  localparam int DIV = 4;
  localparam int DW  = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             tx;
  logic             busy;
  logic [1:0]       grant_id;
  logic             frame_done;

  logic [NR-1:0]    d_req_valid;
  logic [NR*DW-1:0] d_req_data;
  logic [NR-1:0]    d_req_ready;
  logic             d_tx;
  logic             d_busy;
  logic [1:0]       d_grant_id;
  logic             d_frame_done;

  uart_tx_arbiter #(.NUM_REQ(NR), .DIVIDER(DIV), .DATA_W(DW)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id),
    .frame_done(frame_done)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) u_dut_def (
    .clk(clk), .reset(reset), .req_valid(d_req_valid), .req_data(d_req_data),
    .req_ready(d_req_ready), .tx(d_tx), .busy(d_busy), .grant_id(d_grant_id),
    .frame_done(d_frame_done)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  int done_total = 0;
  logic [DW-1:0] exp_q[$];

  always @(negedge clk) if (frame_done) done_total++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic set_data(input int id, input logic [DW-1:0] b);
    req_data[id*DW +: DW] = b;
  endtask

  task automatic wait_accept(output int waits, output logic [NR-1:0] rdy);
    waits = 0;
    #1;
    while (((req_ready & req_valid) == '0) && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    rdy = req_ready & req_valid;
    if (waits >= 200) check("accept_timeout", 32'd1, 32'd0);
  endtask

  // Watches the 10*DIV cycles following an accept and checks the whole frame.
  task automatic capture_frame(input int id, input bit drop);
    logic [DW-1:0] exp_byte;
    logic [DW-1:0] got;
    logic [9:0]    frame;
    int errs, busy_cnt, done_cnt, done_at, bi;
    errs = 0; busy_cnt = 0; done_cnt = 0; done_at = 0; got = '0;
    exp_byte = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    frame = {1'b1, exp_byte, 1'b0};
    for (int c = 1; c <= 10*DIV; c++) begin
      @(negedge clk);
      #1;
      if (drop && c == 1) req_valid[id] = 1'b0;
      bi = (c - 1) / DIV;
      if (tx !== frame[bi]) errs++;
      if (busy) busy_cnt++;
      if (frame_done) begin done_cnt++; done_at = c; end
      if (((c - 1) % DIV) == DIV/2 && bi >= 1 && bi <= DW) got[bi-1] = tx;
    end
    check($sformatf("tx_wave_g%0d", id), errs, 0);
    check($sformatf("byte_g%0d", id), got, exp_byte);
    check($sformatf("busy_len_g%0d", id), busy_cnt, 10*DIV);
    check($sformatf("done_cnt_g%0d", id), done_cnt, 1);
    check($sformatf("done_at_g%0d", id), done_at, 10*DIV);
    check($sformatf("grant_id_g%0d", id), grant_id, id);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int w;
    int done_save;
    int ids[5];
    int low;
    int d_done_at;
    logic [NR-1:0] rdy;
    ids = '{0, 1, 2, 3, 0};

    reset = 1'b1;
    req_valid = '1;
    req_data = '0;
    d_req_valid = '0;
    d_req_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_grant", grant_id, 0);
    check("reset_done", frame_done, 0);
    check("reset_ready", req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    check("idle_tx", tx, 1);

    // round robin with all requesters held valid
    @(negedge clk);
    for (int i = 0; i < NR; i++) set_data(i, 8'h10 + 8'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(8'h10 + 8'(ids[k]));
      wait_accept(w, rdy);
      check($sformatf("rr_ready_%0d", k), rdy, 32'd1 << ids[k]);
      check($sformatf("rr_gap_%0d", k), w, (k == 0) ? 1 - 1 : 1);
      capture_frame(ids[k], 1'b0);
    end
    req_valid = '0;

    // pointer skip: grant 2 leaves ptr at 3, so 0 then 1 follow
    @(negedge clk);
    exp_q.push_back(8'h12);
    req_valid = 4'b0100;
    wait_accept(w, rdy);
    check("skip_ready_2", rdy, 4'b0100);
    capture_frame(2, 1'b1);
    req_valid = 4'b0011;
    exp_q.push_back(8'h10);
    wait_accept(w, rdy);
    check("skip_ready_0", rdy, 4'b0001);
    check("skip_gap_0", w, 1);
    capture_frame(0, 1'b1);
    exp_q.push_back(8'h11);
    wait_accept(w, rdy);
    check("skip_ready_1", rdy, 4'b0010);
    check("skip_gap_1", w, 1);
    capture_frame(1, 1'b1);

    // data stability and a requester that gives up before grant
    @(negedge clk);
    set_data(0, 8'hA5);
    exp_q.push_back(8'hA5);
    req_valid = 4'b0001;
    wait_accept(w, rdy);
    check("stab_ready", rdy, 4'b0001);
    fork
      capture_frame(0, 1'b1);
      begin
        repeat (5) @(negedge clk);
        set_data(0, 8'h00);
        set_data(3, 8'h77);
        req_valid[3] = 1'b1;
        repeat (20) @(negedge clk);
        req_valid[3] = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    #1;
    check("stab_no_ready", req_ready, 0);
    check("stab_idle_busy", busy, 0);

    // reset during data bit 3 of a frame from requester 2 (byte 8'h12)
    @(negedge clk);
    req_valid = 4'b0100;
    wait_accept(w, rdy);
    check("rst_ready", rdy, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    repeat (17) @(negedge clk);
    #1;
    check("rst_pre_tx", tx, 0);
    check("rst_pre_busy", busy, 1);
    done_save = done_total;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_no_done", done_total, done_save);
    for (int i = 0; i < NR; i++) set_data(i, 8'h10 + 8'(i));
    exp_q.push_back(8'h10);
    wait_accept(w, rdy);
    check("rst_after_ready", rdy, 4'b0001);
    check("rst_after_gap", w, 0);
    capture_frame(0, 1'b0);
    req_valid = '0;
    check("done_total", done_total, 10);

    // default divider: 434-cycle start bit, 4340-cycle frame
    @(negedge clk);
    d_req_data[7:0] = 8'hFF;
    d_req_valid = 4'b0001;
    #1;
    check("def_ready", d_req_ready, 4'b0001);
    @(negedge clk);
    d_req_valid = '0;
    low = 0;
    d_done_at = 0;
    for (int c = 1; c <= 5000; c++) begin
      #1;
      if (!d_tx) low++;
      if (d_frame_done) begin
        d_done_at = c;
        break;
      end
      @(negedge clk);
    end
    check("def_start_len", low, 434);
    check("def_frame_len", d_done_at, 4340);
    @(negedge clk);
    #1;
    check("def_idle_busy", d_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit line between NUM_REQ byte requesters using round-robin arbitration.
- Sequences each accepted byte as a 10-bit frame: start bit, DATA_W data bits LSB first, stop bit.
- Each bit lasts DIVIDER clk cycles, timed by an internal baud tick counter. The default DIVIDER gives 115200 baud from a 50 MHz clk.
- Sits between software/DMA byte sources and the serial pad.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIVIDER, 434, clk cycles per bit period (>= 2).
- DATA_W, 8, data bits per frame.
- IDW, $clog2(NUM_REQ), grant index width (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept strobe, combinational, asserted only in IDLE.
- tx  out  1  serial output, registered; idle high.
- busy  out  1  high while a frame is in flight (any state except IDLE).
- grant_id  out  IDW  index of the requester owning the current or last frame.
- frame_done  out  1  one-cycle pulse on the last clk cycle of the stop bit.

Behaviour:
- Reset values (synchronous): tx=1, busy=0, grant_id=0, frame_done=0, req_ready=0, state=IDLE, rr_ptr=0, bit counter=0, baud counter=0.
- Reset asserted mid-frame aborts the frame. tx returns high on the next edge. No accept or frame_done is produced for the aborted byte.
- States:
  - IDLE: if any req_valid is set, the winner is the first set bit searched upward from rr_ptr, modulo NUM_REQ. req_ready[winner]=1 this cycle. Byte latched into shift reg, grant_id<=winner, rr_ptr<=(winner+1)%NUM_REQ, baud counter cleared, ->START. No valid: stay, tx=1.
  - START: tx=0 for DIVIDER cycles, ->DATA with bit index 0.
  - DATA: tx=shift[0] for DIVIDER cycles per bit, shift right. After bit DATA_W-1, ->STOP.
  - STOP: tx=1 for DIVIDER cycles. frame_done=1 on the final cycle. ->IDLE.
- Timing:
  - tx falls on the edge after the accept cycle.
  - Frame length is exactly (DATA_W+2)*DIVIDER cycles from that edge.
  - Minimum gap between frames is 1 idle clk cycle: the first IDLE cycle after STOP can accept.
- Baud tick: a counter 0..DIVIDER-1 emits a tick on count DIVIDER-1, then wraps to 0. It is cleared on accept, so every bit is exactly DIVIDER cycles. The counter width is $clog2(DIVIDER).
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - Requesters must hold valid and data stable until ready. A requester that drops valid before grant is simply skipped.
  - req_data is not sampled outside the accept cycle; changes mid-frame have no effect.
- Arbitration:
  - With all requesters continuously valid, grants rotate 0,1,2,3,0…
  - A lone requester is granted back-to-back frames.
  - The pointer only advances on an accept.
- busy=1 from the edge after accept through the final STOP cycle. It falls on the IDLE entry edge.
- grant_id holds its value after the frame ends until the next accept.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP};
  - constants START_BIT=1'b0, STOP_BIT=1'b1, DEFAULT_DIVIDER=434.
- Sub-module uart_baud_tick (params DIVIDER):
  - ports clk, reset, clear, tick;
  - one-cycle tick every DIVIDER cycles;
  - synchronous clear restarts the count.
- The arbiter and FSM stay in uart_tx_arbiter.

Test Plan:
- Use DIVIDER=4, NUM_REQ=4 unless stated.
- Single byte: req_valid=4'b0001, data0=8'hA5 -> ready[0] pulses 1 cycle. tx over 40 cycles reads 0,1,0,1,0,0,1,0,1,1 (4 cycles each). frame_done pulses on cycle 40. busy high for 40 cycles.
- Round-robin: req_valid=4'b1111 held, data i=8'h10+i -> grants 0,1,2,3,0 in order. Frames carry 10,11,12,13,10. Each accept falls on the first IDLE cycle after the prior frame_done.
- Pointer skip: grant 2 completes, then req_valid=4'b0011 -> requester 0 granted next (wrap from ptr=3), then 1.
- Reset mid-frame: assert reset in DATA bit 3 for 1 cycle -> next edge tx=1, busy=0, rr_ptr=0, no frame_done. A new request is accepted 1 cycle after reset deasserts.
- Data stability: change req_data[0] mid-frame -> transmitted byte is unchanged. A requester that drops valid before grant is never given ready.
- Default timing: DIVIDER=434 -> start bit low for exactly 434 cycles. Full frame is 4340 cycles.
